// File: rtl/pe_tile_array_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_tile_array_pkg                                                          |
// | Default widths and the per-column control bundle shared by the PE tile.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package pe_tile_array_pkg;

    localparam int c_def_rows    = 2;
    localparam int c_def_cols    = 2;
    localparam int c_def_a_w     = 8;
    localparam int c_def_acc_w   = 19;
    localparam int c_def_shift_w = 4;

    typedef struct packed {
        logic                     propagate;
        logic [c_def_shift_w-1:0] shift;
    } pe_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pe_ws_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_ws_cell                                                                 |
// | One weight-stationary PE: double-buffered weights, MAC, registered edges.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pe_ws_cell
    import pe_tile_array_pkg::*;
#(
    parameter int A_W   = c_def_a_w,
    parameter int ACC_W = c_def_acc_w
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [A_W-1:0]   i_a,
    input  logic [ACC_W-1:0] i_b,
    input  logic [ACC_W-1:0] i_d,
    input  pe_ctrl_t         i_ctrl,
    input  logic             i_valid,
    output logic [A_W-1:0]   o_a,
    output logic [ACC_W-1:0] o_b,
    output logic [ACC_W-1:0] o_c,
    output pe_ctrl_t         o_ctrl,
    output logic             o_valid
);

    logic [ACC_W-1:0] r_w0;
    logic [ACC_W-1:0] r_w1;
    logic [A_W-1:0]   r_out_a;
    logic [ACC_W-1:0] r_out_b;
    logic [ACC_W-1:0] r_out_c;
    pe_ctrl_t         r_ctrl;
    logic             r_valid;

    logic [ACC_W-1:0] w_a_ext;
    logic [ACC_W-1:0] w_active;
    logic [ACC_W-1:0] w_preload;
    logic [ACC_W-1:0] w_mac;

    // Operands are pre-extended to ACC_W, so the low ACC_W bits of the
    // unsigned product equal the wrapped two's-complement result.
    assign w_a_ext   = {{(ACC_W-A_W){i_a[A_W-1]}}, i_a};
    assign w_active  = i_ctrl.propagate ? r_w1 : r_w0;
    assign w_preload = i_ctrl.propagate ? r_w0 : r_w1;
    assign w_mac     = i_b + w_a_ext * w_active;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_w0    <= '0;
            r_w1    <= '0;
            r_out_a <= '0;
            r_out_b <= '0;
            r_out_c <= '0;
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_out_a <= i_a;
            r_valid <= i_valid;
            if (i_valid) begin
                r_out_b <= w_mac;
                r_out_c <= w_preload;
                r_ctrl  <= i_ctrl;
                if (i_ctrl.propagate) begin
                    r_w0 <= i_d;
                end else begin
                    r_w1 <= i_d;
                end
            end
        end
    end

    assign o_a     = r_out_a;
    assign o_b     = r_out_b;
    assign o_c     = r_out_c;
    assign o_ctrl  = r_ctrl;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/pe_tile_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_tile_array                                                              |
// | ROWS x COLS grid of weight-stationary PEs; a flows east, b/d flow south.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pe_tile_array
    import pe_tile_array_pkg::*;
#(
    parameter int ROWS    = c_def_rows,
    parameter int COLS    = c_def_cols,
    parameter int A_W     = c_def_a_w,
    parameter int ACC_W   = c_def_acc_w,
    parameter int SHIFT_W = c_def_shift_w
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ROWS*A_W-1:0]      io_in_a,
    input  logic [COLS*ACC_W-1:0]    io_in_b,
    input  logic [COLS*ACC_W-1:0]    io_in_d,
    input  logic [COLS-1:0]          io_in_control_propagate,
    input  logic [COLS*SHIFT_W-1:0]  io_in_control_shift,
    input  logic [COLS-1:0]          io_in_valid,
    output logic [ROWS*A_W-1:0]      io_out_a,
    output logic [COLS*ACC_W-1:0]    io_out_b,
    output logic [COLS*ACC_W-1:0]    io_out_c,
    output logic [COLS-1:0]          io_out_control_propagate,
    output logic [COLS*SHIFT_W-1:0]  io_out_control_shift,
    output logic [COLS-1:0]          io_out_valid
);

    // Index 0 of each chain is the tile edge; the last index is the far edge.
    logic [A_W-1:0]   w_a     [ROWS][COLS+1];
    logic [ACC_W-1:0] w_b     [ROWS+1][COLS];
    logic [ACC_W-1:0] w_d     [ROWS+1][COLS];
    pe_ctrl_t         w_ctrl  [ROWS+1][COLS];
    logic             w_valid [ROWS+1][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_edge_row
        assign w_a[r][0]                = io_in_a[r*A_W +: A_W];
        assign io_out_a[r*A_W +: A_W]   = w_a[r][COLS];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_edge_col
        assign w_b[0][c]                = io_in_b[c*ACC_W +: ACC_W];
        assign w_d[0][c]                = io_in_d[c*ACC_W +: ACC_W];
        assign w_ctrl[0][c].propagate   = io_in_control_propagate[c];
        assign w_ctrl[0][c].shift       = io_in_control_shift[c*SHIFT_W +: SHIFT_W];
        assign w_valid[0][c]            = io_in_valid[c];

        assign io_out_b[c*ACC_W +: ACC_W]           = w_b[ROWS][c];
        assign io_out_c[c*ACC_W +: ACC_W]           = w_d[ROWS][c];
        assign io_out_control_propagate[c]          = w_ctrl[ROWS][c].propagate;
        assign io_out_control_shift[c*SHIFT_W +: SHIFT_W] = w_ctrl[ROWS][c].shift;
        assign io_out_valid[c]                      = w_valid[ROWS][c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            pe_ws_cell #(
                .A_W   (A_W),
                .ACC_W (ACC_W)
            ) u_cell (
                .clock   (clock),
                .reset   (reset),
                .i_a     (w_a[r][c]),
                .i_b     (w_b[r][c]),
                .i_d     (w_d[r][c]),
                .i_ctrl  (w_ctrl[r][c]),
                .i_valid (w_valid[r][c]),
                .o_a     (w_a[r][c+1]),
                .o_b     (w_b[r+1][c]),
                .o_c     (w_d[r+1][c]),
                .o_ctrl  (w_ctrl[r+1][c]),
                .o_valid (w_valid[r+1][c])
            );
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_tile_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pe_tile_array                                                           |
// | Directed and random stimulus against a beat-level reference of the tile.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pe_tile_array;

    localparam int ROWS    = 2;
    localparam int COLS    = 2;
    localparam int A_W     = 8;
    localparam int ACC_W   = 19;
    localparam int SHIFT_W = 4;
    localparam int MAXC    = 2048;
    localparam int AW_T    = ROWS*A_W;
    localparam int BW_T    = COLS*ACC_W;
    localparam int SW_T    = COLS*SHIFT_W;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [AW_T-1:0]       io_in_a;
    logic [BW_T-1:0]       io_in_b;
    logic [BW_T-1:0]       io_in_d;
    logic [COLS-1:0]       io_in_control_propagate;
    logic [SW_T-1:0]       io_in_control_shift;
    logic [COLS-1:0]       io_in_valid;
    logic [AW_T-1:0]       io_out_a;
    logic [BW_T-1:0]       io_out_b;
    logic [BW_T-1:0]       io_out_c;
    logic [COLS-1:0]       io_out_control_propagate;
    logic [SW_T-1:0]       io_out_control_shift;
    logic [COLS-1:0]       io_out_valid;

    always #5 clock = ~clock;

    pe_tile_array #(
        .ROWS(ROWS), .COLS(COLS), .A_W(A_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_in_a                  (io_in_a),
        .io_in_b                  (io_in_b),
        .io_in_d                  (io_in_d),
        .io_in_control_propagate  (io_in_control_propagate),
        .io_in_control_shift      (io_in_control_shift),
        .io_in_valid              (io_in_valid),
        .io_out_a                 (io_out_a),
        .io_out_b                 (io_out_b),
        .io_out_c                 (io_out_c),
        .io_out_control_propagate (io_out_control_propagate),
        .io_out_control_shift     (io_out_control_shift),
        .io_out_valid             (io_out_valid)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Input history per cycle; a beat entering column c at cycle k reaches
    // row r at cycle k+r, where it meets the a that entered row r at k+r-c.
    int     h_a  [MAXC][ROWS];
    longint h_b  [MAXC][COLS];
    longint h_d  [MAXC][COLS];
    int     h_p  [MAXC][COLS];
    int     h_sh [MAXC][COLS];
    int     h_v  [MAXC][COLS];

    longint mw   [ROWS][COLS][2];
    longint e_b  [COLS];
    longint e_c  [COLS];
    int     e_p  [COLS];
    int     e_sh [COLS];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        if (v >= (longint'(1) << (w-1))) return v - (longint'(1) << w);
        return v;
    endfunction

    function automatic longint wrap(input longint v);
        return v & ((longint'(1) << ACC_W) - 1);
    endfunction

    task automatic run_beat(input int k, input int c);
        longint b, d, cout, a;
        int p, t;
        b = h_b[k][c];
        d = h_d[k][c];
        p = h_p[k][c];
        for (int r = 0; r < ROWS; r++) begin
            t = k + r - c;
            a = (t >= 0) ? sx(longint'(h_a[t][r]), A_W) : 0;
            b = wrap(sx(b, ACC_W) + a * sx(mw[r][c][p], ACC_W));
            cout = mw[r][c][1-p];
            mw[r][c][1-p] = d;
            d = cout;
        end
        e_b[c]  = b;
        e_c[c]  = d;
        e_p[c]  = p;
        e_sh[c] = h_sh[k][c];
    endtask

    task automatic cycle();
        int n, k, ka;
        n = cyc;
        for (int r = 0; r < ROWS; r++) h_a[n][r] = int'(io_in_a[r*A_W +: A_W]);
        for (int c = 0; c < COLS; c++) begin
            h_b[n][c]  = longint'(io_in_b[c*ACC_W +: ACC_W]);
            h_d[n][c]  = longint'(io_in_d[c*ACC_W +: ACC_W]);
            h_p[n][c]  = int'(io_in_control_propagate[c]);
            h_sh[n][c] = int'(io_in_control_shift[c*SHIFT_W +: SHIFT_W]);
            h_v[n][c]  = int'(io_in_valid[c]);
        end
        @(posedge clock);
        #1;
        k  = n - ROWS + 1;
        ka = n - COLS + 1;
        if (reset) begin
            for (int j = (n > 8 ? n - 8 : 0); j <= n; j++) begin
                for (int r = 0; r < ROWS; r++) h_a[j][r] = 0;
                for (int c = 0; c < COLS; c++) begin
                    h_b[j][c] = 0; h_d[j][c] = 0; h_p[j][c] = 0; h_sh[j][c] = 0; h_v[j][c] = 0;
                end
            end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    mw[r][c][0] = 0;
                    mw[r][c][1] = 0;
                end
            for (int c = 0; c < COLS; c++) begin
                e_b[c] = 0; e_c[c] = 0; e_p[c] = 0; e_sh[c] = 0;
            end
        end else begin
            for (int c = 0; c < COLS; c++)
                if (k >= 0 && h_v[k][c] != 0) run_beat(k, c);
        end
        for (int r = 0; r < ROWS; r++)
            chk("out_a", 64'(io_out_a[r*A_W +: A_W]), (ka >= 0) ? 64'(h_a[ka][r]) : 64'd0);
        for (int c = 0; c < COLS; c++) begin
            chk("out_b", 64'(io_out_b[c*ACC_W +: ACC_W]), 64'(e_b[c]));
            chk("out_c", 64'(io_out_c[c*ACC_W +: ACC_W]), 64'(e_c[c]));
            chk("out_prop", 64'(io_out_control_propagate[c]), 64'(e_p[c]));
            chk("out_shift", 64'(io_out_control_shift[c*SHIFT_W +: SHIFT_W]), 64'(e_sh[c]));
            chk("out_valid", 64'(io_out_valid[c]), (k >= 0) ? 64'(h_v[k][c]) : 64'd0);
        end
        cyc++;
    endtask

    task automatic idle();
        io_in_a                 = '0;
        io_in_b                 = '0;
        io_in_d                 = '0;
        io_in_control_propagate = '0;
        io_in_control_shift     = '0;
        io_in_valid             = '0;
    endtask

    task automatic randomize_inputs();
        io_in_a                 = AW_T'($urandom);
        io_in_b                 = BW_T'({$urandom, $urandom});
        io_in_d                 = BW_T'({$urandom, $urandom});
        io_in_control_propagate = COLS'($urandom);
        io_in_control_shift     = SW_T'($urandom);
        io_in_valid             = COLS'($urandom);
    endtask

    initial begin
        // Reset with garbage on the inputs
        reset = 1'b1;
        randomize_inputs();
        cycle();
        randomize_inputs();
        cycle();
        chk("rst_b", 64'(io_out_b), 64'd0);
        chk("rst_a", 64'(io_out_a), 64'd0);
        chk("rst_valid", 64'(io_out_valid), 64'd0);
        reset = 1'b0;
        idle();
        io_in_valid[0] = 1'b1;
        io_in_a[0 +: A_W] = 8'd7;
        cycle();
        idle();
        cycle();
        chk("rst_wzero_b", 64'(io_out_b[0 +: ACC_W]), 64'd0);
        chk("rst_wzero_v", 64'(io_out_valid[0]), 64'd1);

        // Preload 5,3 into bank 0 of column 0, then compute with bank 0
        idle();
        io_in_valid[0] = 1'b1; io_in_control_propagate[0] = 1'b1; io_in_d[0 +: ACC_W] = 19'd5;
        cycle();
        io_in_d[0 +: ACC_W] = 19'd3;
        cycle();
        io_in_control_propagate[0] = 1'b0; io_in_d[0 +: ACC_W] = '0; io_in_a[0 +: A_W] = 8'd2;
        cycle();
        idle();
        io_in_a[A_W +: A_W] = 8'd4;
        cycle();
        chk("compute_b", 64'(io_out_b[0 +: ACC_W]), 64'd26);
        chk("compute_v", 64'(io_out_valid[0]), 64'd1);

        // Reload bank 0; old contents read back on the south edge
        idle();
        io_in_valid[0] = 1'b1; io_in_control_propagate[0] = 1'b1; io_in_d[0 +: ACC_W] = 19'd9;
        cycle();
        io_in_d[0 +: ACC_W] = 19'd8;
        cycle();
        chk("readback0", 64'(io_out_c[0 +: ACC_W]), 64'd5);
        idle();
        cycle();
        chk("readback1", 64'(io_out_c[0 +: ACC_W]), 64'd3);
        cycle();

        // Overflow: column 1 weight 2^17, a=4, b=2^18-1
        idle();
        io_in_valid[1] = 1'b1; io_in_control_propagate[1] = 1'b0;
        cycle();
        io_in_d[ACC_W +: ACC_W] = 19'h20000; io_in_a[0 +: A_W] = 8'd4;
        cycle();
        idle();
        io_in_valid[1] = 1'b1; io_in_control_propagate[1] = 1'b1;
        io_in_b[ACC_W +: ACC_W] = 19'h3FFFF;
        cycle();
        idle();
        cycle();
        chk("overflow_b", 64'(io_out_b[ACC_W +: ACC_W]), 64'h3FFFF);

        // Bubble in the middle of a preload
        idle();
        io_in_valid[0] = 1'b1; io_in_d[0 +: ACC_W] = 19'd11;
        cycle();
        io_in_valid[0] = 1'b0; io_in_d[0 +: ACC_W] = 19'd77;
        cycle();
        io_in_valid[0] = 1'b1; io_in_d[0 +: ACC_W] = 19'd13;
        cycle();
        io_in_control_propagate[0] = 1'b1; io_in_d[0 +: ACC_W] = '0; io_in_a[0 +: A_W] = 8'd1;
        cycle();
        idle();
        io_in_a[A_W +: A_W] = 8'd1;
        cycle();
        chk("bubble_b", 64'(io_out_b[0 +: ACC_W]), 64'd24);

        // Control pass-through on column 1, a=0x80 on row 0
        idle();
        io_in_valid[1] = 1'b1;
        io_in_control_shift[SHIFT_W +: SHIFT_W] = 4'hA;
        io_in_a[0 +: A_W] = 8'h80;
        cycle();
        io_in_a[0 +: A_W] = '0;
        io_in_control_propagate[1] = 1'b1;
        cycle();
        chk("pass_a", 64'(io_out_a[0 +: A_W]), 64'h80);
        chk("pass_shift", 64'(io_out_control_shift[SHIFT_W +: SHIFT_W]), 64'hA);
        chk("pass_prop", 64'(io_out_control_propagate[1]), 64'd0);
        io_in_control_propagate[1] = 1'b0;
        cycle();
        chk("pass_prop2", 64'(io_out_control_propagate[1]), 64'd1);
        idle();
        cycle();
        cycle();

        // Random traffic with occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
